// File: rtl/encoder_poll_ctrl_pkg.sv
// Shared definitions for the encoder poll controller: FSM states, AXI
// response codes, encoder register offsets and snapshot geometry.
package encoder_poll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_PUBLISH = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] REG0_OFS = 4'h0;
    localparam logic [3:0] REG1_OFS = 4'h4;
    localparam logic [3:0] REG2_OFS = 4'h8;
    localparam logic [3:0] REG3_OFS = 4'hC;

    localparam int REG_W    = 32;
    localparam int MAX_REGS = 4;
    localparam int SNAP_W   = REG_W * MAX_REGS;

    // Byte offset of encoder register idx (registers are word spaced).
    function automatic logic [3:0] reg_offset(input logic [1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/encoder_poll_ctrl_if.sv
// AXI4-Lite bus between the poll controller (master) and the encoder
// register block (slave): 4-bit byte address, 32-bit data.
interface encoder_poll_ctrl_if;

    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/encoder_poll_ctrl_poll_tick_gen.sv
// Poll period generator: counts 0..C_POLL_DIV-1 while enabled and flags
// the wrap cycle; the count is parked at zero whenever enable is low.
module poll_tick_gen #(
    parameter int C_POLL_DIV = 1000
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(C_POLL_DIV);
    localparam logic [CW-1:0] LAST = CW'(C_POLL_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Free-running period counter, restarted from zero on every enable
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/encoder_poll_ctrl.sv
// Encoder poll controller: periodically reads C_NUM_REGS encoder registers
// over AXI4-Lite, publishes a consistent snapshot when every read was OKAY,
// and forwards single configuration writes from the cfg handshake.
module encoder_poll_ctrl
    import encoder_poll_ctrl_pkg::*;
#(
    parameter int C_POLL_DIV = 1000,
    parameter int C_NUM_REGS = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_addr,
    input  logic [31:0]         cfg_data,
    encoder_poll_ctrl_if.master m_axi,
    output logic                snap_valid,
    output logic [SNAP_W-1:0]   snap_data,
    output logic                err,
    output logic                overrun
);

    localparam logic [1:0] LAST_IDX = 2'(C_NUM_REGS - 1);

    state_t            state;
    logic [1:0]        idx;
    logic              poll_pending;
    logic              poll_bad;
    logic              aw_busy;
    logic              w_busy;
    logic [3:0]        aw_addr_q;
    logic [31:0]       w_data_q;
    logic [REG_W-1:0]  shadow [MAX_REGS];
    logic [SNAP_W-1:0] shadow_flat;
    logic              tick;
    logic              cfg_fire;
    logic              poll_start;
    logic              aw_done;
    logic              w_done;
    logic              r_fire;

    poll_tick_gen #(.C_POLL_DIV(C_POLL_DIV)) u_tick (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .enable (enable),
        .tick   (tick)
    );

    // Config writes win over a pending poll when both are ready in IDLE.
    assign cfg_ready  = (state == ST_IDLE) && !ARESET;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign poll_start = (state == ST_IDLE) && poll_pending && !cfg_fire;
    assign aw_done    = !aw_busy || m_axi.awready;
    assign w_done     = !w_busy || m_axi.wready;
    assign r_fire     = (state == ST_RD_R) && m_axi.rvalid;

    assign m_axi.awaddr  = aw_addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = aw_busy;
    assign m_axi.wdata   = w_data_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = w_busy;
    assign m_axi.bready  = (state == ST_WR_B);
    assign m_axi.araddr  = reg_offset(idx);
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state == ST_RD_AR);
    assign m_axi.rready  = (state == ST_RD_R);

    // Pack the shadow slots that are actually polled; unused slots read zero
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            if (i < C_NUM_REGS) begin
                shadow_flat[REG_W*i +: REG_W] = shadow[i];
            end
        end
    end

    // Tick bookkeeping: one poll may wait; a tick finding one already waiting is lost
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            poll_pending <= 1'b0;
            overrun      <= 1'b0;
        end else if (tick) begin
            if (poll_pending && !poll_start) begin
                overrun <= 1'b1;
            end else begin
                poll_pending <= 1'b1;
            end
        end else if (poll_start) begin
            poll_pending <= 1'b0;
        end
    end

    // Write payload and read shadow: plain data, only sampled under a handshake
    always_ff @(posedge ACLK) begin
        if (cfg_fire) begin
            aw_addr_q <= cfg_addr;
            w_data_q  <= cfg_data;
        end
        if (r_fire) begin
            shadow[idx] <= m_axi.rdata;
        end
    end

    // Main sequencer: config write, then register reads and snapshot publish
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            poll_bad   <= 1'b0;
            aw_busy    <= 1'b0;
            w_busy     <= 1'b0;
            err        <= 1'b0;
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else begin
            snap_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        aw_busy <= 1'b1;
                        w_busy  <= 1'b1;
                        state   <= ST_WR;
                    end else if (poll_start) begin
                        idx      <= 2'd0;
                        poll_bad <= 1'b0;
                        state    <= ST_RD_AR;
                    end
                end
                ST_WR: begin
                    if (aw_busy && m_axi.awready) aw_busy <= 1'b0;
                    if (w_busy && m_axi.wready)   w_busy  <= 1'b0;
                    if (aw_done && w_done)        state   <= ST_WR_B;
                end
                ST_WR_B: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != RESP_OKAY) err <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_RD_AR: begin
                    if (m_axi.arready) state <= ST_RD_R;
                end
                ST_RD_R: begin
                    if (m_axi.rvalid) begin
                        if (m_axi.rresp != RESP_OKAY) begin
                            err      <= 1'b1;
                            poll_bad <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= ST_PUBLISH;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= ST_RD_AR;
                        end
                    end
                end
                ST_PUBLISH: begin
                    if (!poll_bad) begin
                        snap_data  <= shadow_flat;
                        snap_valid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_poll_ctrl.sv
// Bench for encoder_poll_ctrl: AXI4-Lite slave model, snapshot scoreboard,
// table of poll vectors and hand-written multi-cycle corner cases.
module tb_encoder_poll_ctrl;
    import encoder_poll_ctrl_pkg::*;

    localparam int DIV  = 16;
    localparam int NREG = 4;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic         enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [3:0]   cfg_addr = 4'h0;
    logic [31:0]  cfg_data = 32'h0;
    logic         snap_valid;
    logic [127:0] snap_data;
    logic         err;
    logic         overrun;

    encoder_poll_ctrl_if axi ();

    encoder_poll_ctrl #(.C_POLL_DIV(DIV), .C_NUM_REGS(NREG)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .m_axi      (axi),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .err        (err),
        .overrun    (overrun)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   resp;
        logic         good;
        logic         exp_err;
    } vec_t;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [31:0]  rd_mem [4];
    logic [1:0]   rd_resp [4];
    logic [1:0]   b_resp_cfg = 2'b00;
    int           ar_hold = 0;
    logic [3:0]   ar_last = 4'h0;
    logic [3:0]   ar_log [$];
    logic [3:0]   aw_log [$];
    logic [31:0]  w_log [$];
    logic [3:0]   last_wstrb = 4'h0;
    logic [127:0] exp_snap [$];
    logic [127:0] model_snap = '0;
    int           ev_seq = 0;
    int           aw_ev = 0;
    int           ar_ev = 0;
    int           rd_count = 0;
    int           b_count = 0;
    int           snap_count = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Slave model and snapshot monitor, evaluated on the falling edge.
    task automatic slave_step();
        if (snap_valid) begin
            snap_count++;
            if (exp_snap.size() == 0) fail_msg("unexpected_snap_valid");
            else check("snap_scoreboard", snap_data, exp_snap.pop_front());
        end
        if (ARESET) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
            axi.arready = 1'b0; axi.rvalid = 1'b0;
            return;
        end
        if (axi.awvalid && !axi.awready) begin
            axi.awready = 1'b1; aw_log.push_back(axi.awaddr);
            ev_seq++; aw_ev = ev_seq;
        end else axi.awready = 1'b0;
        if (axi.wvalid && !axi.wready) begin
            axi.wready = 1'b1; w_log.push_back(axi.wdata); last_wstrb = axi.wstrb;
        end else axi.wready = 1'b0;
        if (axi.bvalid) axi.bvalid = 1'b0;
        else if (axi.bready) begin
            axi.bvalid = 1'b1; axi.bresp = b_resp_cfg; b_count++;
        end
        if (axi.arvalid && !axi.arready) begin
            if (ar_hold > 0) ar_hold--;
            else begin
                axi.arready = 1'b1; ar_log.push_back(axi.araddr); ar_last = axi.araddr;
                ev_seq++; if (ar_ev == 0) ar_ev = ev_seq;
            end
        end else axi.arready = 1'b0;
        if (axi.rvalid) axi.rvalid = 1'b0;
        else if (axi.rready) begin
            axi.rvalid = 1'b1;
            axi.rdata  = rd_mem[ar_last[3:2]];
            axi.rresp  = rd_resp[ar_last[3:2]];
            rd_count++;
        end
    endtask

    task automatic load_slave(input logic [127:0] data, input logic [7:0] resp);
        for (int i = 0; i < 4; i++) begin
            rd_mem[i]  = data[32*i +: 32];
            rd_resp[i] = resp[2*i +: 2];
        end
    endtask

    task automatic check_ar_polls(input int polls);
        check("ar_count", 128'(ar_log.size()), 128'(polls * NREG));
        for (int p = 0; p < polls; p++) begin
            for (int i = 0; i < NREG; i++) begin
                if (ar_log.size() > 0) check("araddr", 128'(ar_log.pop_front()), 128'(i * 4));
            end
        end
    endtask

    task automatic wait_reads(input int target, input int bound, input string name);
        int t = 0;
        while (rd_count < target && t < bound) begin @(negedge ACLK); t++; end
        if (rd_count < target) fail_msg(name);
        repeat (4) @(negedge ACLK);
    endtask

    // One isolated poll: enable until the first read address appears.
    task automatic do_poll(input logic [127:0] data, input logic [7:0] resp, input logic good);
        int t = 0;
        int start = rd_count;
        ar_log.delete();
        load_slave(data, resp);
        if (good) begin exp_snap.push_back(data); model_snap = data; end
        enable = 1'b1;
        while (!axi.arvalid && t < 40) begin @(negedge ACLK); t++; end
        if (!axi.arvalid) fail_msg("poll_start_wait");
        enable = 1'b0;
        wait_reads(start + NREG, 100, "poll_reads_wait");
        check("snap_data", snap_data, model_snap);
        check_ar_polls(1);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        int t = 0;
        while (!cfg_ready && t < 50) begin @(negedge ACLK); t++; end
        if (!cfg_ready) fail_msg("cfg_ready_wait");
        cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
        @(negedge ACLK);
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_ready"}, 128'(cfg_ready), 128'(0));
        check({tag, "_snap_valid"}, 128'(snap_valid), 128'(0));
        check({tag, "_snap_data"}, snap_data, 128'h0);
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_overrun"}, 128'(overrun), 128'(0));
        check({tag, "_axi_ctl"}, 128'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 128'(0));
    endtask

    task automatic main_seq();
        vec_t vecs [4];
        int t;
        int b0;
        int s0;
        int r0;
        vecs[0] = '{128'h00000044_00000033_00000022_00000011, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{128'hFFFFFFFF_89ABCDEF_01234567_DEADBEEF, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{128'h00000004_00000003_00000002_00000001, 8'b00_00_10_00, 1'b0, 1'b1};
        vecs[3] = '{128'h3C3C3C3C_C3C3C3C3_5A5A5A5A_A5A5A5A5, 8'h00, 1'b1, 1'b1};

        #2;
        check_reset_values("por");
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Single config write, slave ready immediately.
        b0 = b_count;
        cfg_write(4'h4, 32'h0000_00A5);
        t = 0;
        while (!(b_count > b0 && cfg_ready) && t < 40) begin @(negedge ACLK); t++; end
        if (!(b_count > b0 && cfg_ready)) fail_msg("cfg_b_wait");
        check("cfg_b_count", 128'(b_count - b0), 128'(1));
        check("cfg_aw_count", 128'(aw_log.size()), 128'(1));
        if (aw_log.size() > 0) check("cfg_awaddr", 128'(aw_log.pop_front()), 128'h4);
        if (w_log.size() > 0) check("cfg_wdata", 128'(w_log.pop_front()), 128'hA5);
        else fail_msg("cfg_wdata_missing");
        check("cfg_wstrb", 128'(last_wstrb), 128'hF);
        check("cfg_err", 128'(err), 128'(0));
        check("cfg_ready_back", 128'(cfg_ready), 128'(1));

        // Table of polls: good data, all-ones pattern, SLVERR on reg 1, good after error.
        for (int i = 0; i < 4; i++) begin
            s0 = snap_count;
            do_poll(vecs[i].data, vecs[i].resp, vecs[i].good);
            check("vec_snap_pulses", 128'(snap_count - s0), 128'(vecs[i].good ? 1 : 0));
            check("vec_err", 128'(err), 128'(vecs[i].exp_err));
            check("vec_overrun", 128'(overrun), 128'(0));
        end

        // Reset pulsed while a read response is awaited.
        load_slave(128'h00000008_00000007_00000006_00000005, 8'h00);
        ar_log.delete();
        enable = 1'b1;
        t = 0;
        while (!axi.rready && t < 60) begin @(negedge ACLK); t++; end
        if (!axi.rready) fail_msg("rd_r_wait");
        enable = 1'b0;
        #2 ARESET = 1'b1;
        #1;
        check_reset_values("mid_rd_r");
        repeat (2) @(posedge ACLK);
        #2 ARESET = 1'b0;
        @(negedge ACLK);
        model_snap = '0;
        s0 = snap_count;
        repeat (20) @(negedge ACLK);
        check("rst_no_snap", 128'(snap_count - s0), 128'(0));
        check("rst_snap_data", snap_data, 128'h0);
        do_poll(128'h00000008_00000007_00000006_00000005, 8'h00, 1'b1);

        // Config request arrives in the same cycle as a poll tick.
        load_slave(128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 8'h00);
        ar_log.delete();
        aw_log.delete();
        w_log.delete();
        aw_ev = 0;
        ar_ev = 0;
        exp_snap.push_back(128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001);
        model_snap = 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001;
        r0 = rd_count;
        enable = 1'b1;
        repeat (DIV - 1) @(posedge ACLK);
        @(negedge ACLK);
        cfg_addr = 4'h8; cfg_data = 32'h0000_005A; cfg_valid = 1'b1;
        @(negedge ACLK);
        cfg_valid = 1'b0;
        t = 0;
        while (!axi.arvalid && t < 40) begin @(negedge ACLK); t++; end
        if (!axi.arvalid) fail_msg("tie_poll_wait");
        enable = 1'b0;
        wait_reads(r0 + NREG, 100, "tie_reads_wait");
        check("tie_order", 128'(aw_ev != 0 && ar_ev != 0 && aw_ev < ar_ev), 128'(1));
        if (aw_log.size() > 0) check("tie_awaddr", 128'(aw_log.pop_front()), 128'h8);
        else fail_msg("tie_aw_missing");
        if (w_log.size() > 0) check("tie_wdata", 128'(w_log.pop_front()), 128'h5A);
        else fail_msg("tie_w_missing");
        check("tie_snap_data", snap_data, model_snap);
        check_ar_polls(1);

        // ARREADY withheld long enough for a tick to be dropped.
        load_slave(128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001, 8'h00);
        ar_log.delete();
        exp_snap.push_back(128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001);
        exp_snap.push_back(128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001);
        model_snap = 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001;
        s0 = snap_count;
        r0 = rd_count;
        ar_hold = 40;
        check("ovr_before", 128'(overrun), 128'(0));
        enable = 1'b1;
        t = 0;
        while (!overrun && t < 100) begin @(negedge ACLK); t++; end
        if (!overrun) fail_msg("overrun_wait");
        enable = 1'b0;
        wait_reads(r0 + 2 * NREG, 200, "ovr_reads_wait");
        repeat (40) @(negedge ACLK);
        check("ovr_flag", 128'(overrun), 128'(1));
        check("ovr_snap_pulses", 128'(snap_count - s0), 128'(2));
        check("ovr_snap_data", snap_data, model_snap);
        check("ovr_err", 128'(err), 128'(0));
        check_ar_polls(2);
        check("scoreboard_drained", 128'(exp_snap.size()), 128'(0));
    endtask

    initial begin
        fork
            main_seq();
            forever begin
                @(negedge ACLK);
                slave_step();
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/encoder_poll_ctrl.md
ENCODER_POLL_CTRL -- requirements
Module: encoder_poll_ctrl

Interface
REQ-001 SHALL have parameter C_POLL_DIV, default 1000, meaning the poll period in ACLK cycles (legal range 8..65535).
REQ-002 SHALL have parameter C_NUM_REGS, default 4, meaning the number of 32-bit registers read per poll at byte addresses 0x0, 0x4, ... (legal range 1..4).
REQ-003 ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  periodic polling allowed while high.
REQ-006 cfg_valid / cfg_ready  in / out  1  config-write handshake; transfer occurs when both are high.
REQ-007 cfg_addr / cfg_data  in  4 / 32  config register byte address and data.
REQ-008 m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mixed  AXI4-Lite master, 4-bit address, 32-bit data, PROT fixed 3'b000, WSTRB fixed 4'hF.
REQ-009 snap_valid  out  1  one-cycle pulse: new snapshot available.
REQ-010 snap_data  out  128  snapshot; register n in bits [32n+31:32n]; unused slots zero.
REQ-011 err  out  1  sticky: any non-OKAY BRESP/RRESP seen.
REQ-012 overrun  out  1  sticky: a poll tick was dropped.

Function
REQ-013 FSM states: IDLE, WR (AW+W outstanding), WR_B, RD_AR, RD_R, PUBLISH.
REQ-014 cfg_ready SHALL be high only in IDLE; a config transfer takes priority over a pending poll in the same cycle.
REQ-015 IDLE->WR on config transfer: AWVALID and WVALID asserted in the next cycle; each deasserts independently once its READY is sampled high; when both have completed -> WR_B.
REQ-016 WR_B: BREADY high; on BVALID -> IDLE; BRESP != OKAY sets err.
REQ-017 Poll timer: counts 0..C_POLL_DIV-1 while enable high, generating a tick on wrap; held at 0 while enable low.
REQ-018 A tick sets poll_pending; a tick arriving while poll_pending is already set sets overrun and is discarded.
REQ-019 IDLE with poll_pending and no config transfer -> RD_AR with index 0; poll_pending clears on entry.
REQ-020 RD_AR: ARVALID high with ARADDR = 4*index until ARREADY -> RD_R; only one read outstanding.
REQ-021 RD_R: RREADY high; on RVALID capture RDATA into shadow slot index; if index = C_NUM_REGS-1 -> PUBLISH, else index+1 -> RD_AR.
REQ-022 RRESP != OKAY SHALL set err and mark the current poll bad; the sequence still completes.
REQ-023 PUBLISH lasts one cycle: if the poll is good, copy shadow to snap_data and pulse snap_valid; a bad poll leaves snap_data unchanged with no pulse; -> IDLE.
REQ-024 snap_data changes only in PUBLISH.
REQ-025 Deasserting enable mid-poll SHALL NOT abort the sequence.
REQ-026 AXI VALID signals SHALL NOT drop before their READY, and address/data SHALL be stable while VALID is high.

Reset
REQ-027 ARESET SHALL asynchronously force: state IDLE, all VALID/READY outputs 0, cfg_ready 0 while asserted, snap_valid 0, snap_data 0, err 0, overrun 0, timer 0, poll_pending 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction; no partial snapshot is published.

Structure
REQ-029 The shared package SHALL hold the FSM state enum, the AXI response constants (OKAY=2'b00), the register-offset constants and the snapshot width.
REQ-030 The poll timer SHALL be a sub-module, poll_tick_gen (C_POLL_DIV, enable in, tick out).

Verification
REQ-031 Config write addr 0x4 data 0x0000_00A5, slave ready immediately -> one AW/W at 0x4/0xA5, B OKAY, err=0, cfg_ready back high.
REQ-032 enable=1, C_POLL_DIV=16, slave returns 0x11,0x22,0x33,0x44 -> reads at 0x0,0x4,0x8,0xC, snap_valid once, snap_data=0x00000044_00000033_00000022_00000011.
REQ-033 Second read returns RRESP=SLVERR -> err=1, no snap_valid, snap_data keeps the previous value.
REQ-034 cfg_valid and a tick in the same IDLE cycle -> write completes first, then the poll runs.
REQ-035 ARREADY withheld for 40 cycles with C_POLL_DIV=16 -> overrun=1, exactly one follow-up poll.
REQ-036 ARESET pulsed during RD_R -> all outputs at reset values, no snap_valid, polling resumes at address 0x0.
